// File: rtl/fpu_seq_pkg.sv
// rtl/fpu_seq_pkg.sv - shared types, opcodes and latency lookup for the FPU issue sequencer
package fpu_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // FPU opcodes, encoded to match the control unit's FPUOpcode field
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MULT  = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_NEG   = 4'b0100;
  localparam logic [3:0] OP_ROUND = 4'b0101;
  localparam logic [3:0] OP_F2B   = 4'b0110;
  localparam logic [3:0] OP_B2F   = 4'b0111;
  localparam logic [3:0] OP_CEQ   = 4'b1000;
  localparam logic [3:0] OP_CNE   = 4'b1001;
  localparam logic [3:0] OP_CLT   = 4'b1010;
  localparam logic [3:0] OP_CLE   = 4'b1011;
  localparam logic [3:0] OP_CGT   = 4'b1100;
  localparam logic [3:0] OP_CGE   = 4'b1101;
  localparam logic [3:0] OP_MTF   = 4'b1110;
  localparam logic [3:0] OP_MFF   = 4'b1111;

  // Latency value reserved for ops that finish on fpu_done instead of a count
  localparam logic [3:0] LAT_VARIABLE = 4'd0;

  // Cycles from fpu_start to a valid result, plus one; 0 means variable latency
  function automatic logic [3:0] fpu_latency(input logic [3:0] op);
    logic [3:0] lat;
    lat = 4'd1;
    case (op)
      OP_ADD:   lat = 4'd2;
      OP_SUB:   lat = 4'd2;
      OP_MULT:  lat = 4'd3;
      OP_DIV:   lat = LAT_VARIABLE;
      OP_NEG:   lat = 4'd1;
      OP_ROUND: lat = 4'd2;
      OP_F2B:   lat = 4'd2;
      OP_B2F:   lat = 4'd2;
      OP_MTF:   lat = 4'd1;
      OP_MFF:   lat = 4'd1;
      default:  lat = 4'd1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/fpu_sequencer.sv
// rtl/fpu_sequencer.sv - multi-cycle issue controller between decode and the FPU core
module fpu_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              issue_valid,
  input  logic [3:0]        issue_opcode,
  input  logic              issue_fp_we,
  input  logic [4:0]        issue_dest,
  output logic              issue_ready,
  output logic              stall,
  output logic              fpu_start,
  output logic [3:0]        fpu_opcode,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_result,
  output logic              wb_valid,
  output logic              wb_fp,
  output logic [4:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  // Timer is wide enough to hold TIMEOUT_CYCLES-1
  localparam int             TW          = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]  TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [3:0]    count;
  logic [TW-1:0] timer;
  logic [3:0]    issue_lat;

  assign issue_lat = fpu_latency(issue_opcode);

  // Handshake outputs depend on the live issue_valid so decode freezes in the accept cycle
  assign issue_ready = (state == ST_IDLE);
  assign stall       = ((state == ST_IDLE) && issue_valid) ||
                       (state == ST_EXEC) || (state == ST_WAIT);

  // Sequencer FSM with registered start, writeback and error outputs
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state      <= ST_IDLE;
      count      <= 4'd0;
      timer      <= '0;
      fpu_start  <= 1'b0;
      fpu_opcode <= 4'd0;
      wb_valid   <= 1'b0;
      wb_fp      <= 1'b0;
      wb_dest    <= 5'd0;
      wb_data    <= '0;
      err        <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      wb_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue_valid) begin
            fpu_opcode <= issue_opcode;
            wb_dest    <= issue_dest;
            wb_fp      <= issue_fp_we;
            fpu_start  <= 1'b1;
            timer      <= '0;
            if (issue_lat == LAT_VARIABLE) begin
              count <= 4'd0;
              state <= ST_WAIT;
            end else begin
              count <= issue_lat - 4'd1;
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          // fpu_done is deliberately ignored here; the count alone decides
          if (count == 4'd0) begin
            wb_data  <= fpu_result;
            wb_valid <= 1'b1;
            state    <= ST_WB;
          end else begin
            count <= count - 4'd1;
          end
        end
        ST_WAIT: begin
          // Completion is checked first so a late done still beats the timeout
          if (fpu_done) begin
            wb_data  <= fpu_result;
            wb_valid <= 1'b1;
            state    <= ST_WB;
          end else if (timer == TIMER_LAST) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb/tb_fpu_sequencer.sv - scoreboard bench for the FPU issue sequencer
module tb_fpu_sequencer;
  import fpu_seq_pkg::*;

  logic        clk;
  logic        rst_b;
  logic        issue_valid;
  logic [3:0]  issue_opcode;
  logic        issue_fp_we;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic        stall;
  logic        fpu_start;
  logic [3:0]  fpu_opcode;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        wb_valid;
  logic        wb_fp;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        err;

  typedef struct packed {
    logic        fp;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  wb_count   = 0;

  fpu_sequencer #(.TIMEOUT_CYCLES(8), .DATA_W(32)) dut (
    .clk(clk), .rst_b(rst_b),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_fp_we(issue_fp_we), .issue_dest(issue_dest),
    .issue_ready(issue_ready), .stall(stall),
    .fpu_start(fpu_start), .fpu_opcode(fpu_opcode),
    .fpu_done(fpu_done), .fpu_result(fpu_result),
    .wb_valid(wb_valid), .wb_fp(wb_fp), .wb_dest(wb_dest),
    .wb_data(wb_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every writeback pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst_b && wb_valid) begin
      wb_count++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_wb: got dest %0d data %h expected no writeback", wb_dest, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_fp", {31'd0, wb_fp}, {31'd0, e.fp});
        chk("wb_dest", {27'd0, wb_dest}, {27'd0, e.dest});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fixed-latency op: result presented only in cycle T(L), writeback expected at T(L+1)
  task automatic run_fixed(input logic [3:0] op, input logic fp_we, input logic [4:0] dest,
                           input logic [31:0] data, input int lat);
    exp_q.push_back('{fp: fp_we, dest: dest, data: data});
    issue_valid = 1'b1; issue_opcode = op; issue_fp_we = fp_we; issue_dest = dest;
    @(negedge clk);
    chk("t0_stall", {31'd0, stall}, 32'd1);
    chk("t0_ready", {31'd0, issue_ready}, 32'd1);
    for (int k = 1; k <= lat; k++) begin
      step();
      if (k == 1) issue_valid = 1'b0;
      fpu_result = (k == lat) ? data : (32'hDEAD0000 | k);
      @(negedge clk);
      chk("exec_stall", {31'd0, stall}, 32'd1);
      chk("exec_start", {31'd0, fpu_start}, {31'd0, (k == 1)});
      chk("exec_opcode", {28'd0, fpu_opcode}, {28'd0, op});
    end
    step();
    fpu_result = 32'hBAD0BAD0;
    @(negedge clk);
    chk("wb_pulse", {31'd0, wb_valid}, 32'd1);
    chk("wb_stall", {31'd0, stall}, 32'd0);
    step();
  endtask

  // DIV: done_cycle 0 means the core never answers; err_in is the err value before the op
  task automatic run_div(input logic [4:0] dest, input logic [31:0] data,
                         input int done_cycle, input logic err_in);
    int last;
    last = (done_cycle == 0) ? 8 : done_cycle;
    if (done_cycle != 0) exp_q.push_back('{fp: 1'b1, dest: dest, data: data});
    issue_valid = 1'b1; issue_opcode = OP_DIV; issue_fp_we = 1'b1; issue_dest = dest;
    step();
    issue_valid = 1'b0;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) step();
      fpu_done   = (k == done_cycle);
      fpu_result = (k == done_cycle) ? data : (32'hD1D00000 | k);
      @(negedge clk);
      chk("wait_stall", {31'd0, stall}, 32'd1);
      chk("wait_start", {31'd0, fpu_start}, {31'd0, (k == 1)});
      chk("wait_err", {31'd0, err}, {31'd0, err_in});
      chk("wait_wb", {31'd0, wb_valid}, 32'd0);
    end
    step();
    fpu_done = 1'b0;
    fpu_result = 32'hBAD0BAD0;
    @(negedge clk);
    if (done_cycle != 0) begin
      chk("div_wb_pulse", {31'd0, wb_valid}, 32'd1);
      chk("div_err", {31'd0, err}, {31'd0, err_in});
    end else begin
      chk("to_wb_none", {31'd0, wb_valid}, 32'd0);
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_ready", {31'd0, issue_ready}, 32'd1);
      chk("to_stall", {31'd0, stall}, 32'd0);
    end
    step();
  endtask

  initial begin
    int wb_before;
    rst_b = 1'b1; issue_valid = 1'b0; issue_opcode = 4'd0; issue_fp_we = 1'b0;
    issue_dest = 5'd0; fpu_done = 1'b0; fpu_result = 32'd0;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_start", {31'd0, fpu_start}, 32'd0);
    chk("rst_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_dest", {27'd0, wb_dest}, 32'd0);
    step();
    rst_b = 1'b0;
    step();

    run_fixed(OP_ADD, 1'b1, 5'd3, 32'h40400000, 2);
    run_fixed(OP_MFF, 1'b0, 5'd7, 32'h12345678, 1);
    run_fixed(OP_MULT, 1'b1, 5'd12, 32'h3F800000, 3);
    run_fixed(OP_CLT, 1'b0, 5'd31, 32'h00000001, 1);

    run_div(5'd9, 32'h3EAAAAAB, 5, 1'b0);
    run_div(5'd10, 32'h0, 0, 1'b0);
    run_div(5'd11, 32'hC0000000, 8, 1'b1);

    // Reset during a MULT in flight
    wb_before = wb_count;
    issue_valid = 1'b1; issue_opcode = OP_MULT; issue_fp_we = 1'b1; issue_dest = 5'd4;
    step();
    issue_valid = 1'b0;
    step();
    rst_b = 1'b1;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_start", {31'd0, fpu_start}, 32'd0);
    chk("arst_opcode", {28'd0, fpu_opcode}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_ready", {31'd0, issue_ready}, 32'd1);
    step();
    rst_b = 1'b0;
    fpu_result = 32'h55555555;
    for (int i = 0; i < 5; i++) step();
    chk("arst_no_wb", wb_count, wb_before);
    run_fixed(OP_ADD, 1'b1, 5'd5, 32'h41200000, 2);

    // SUB then NEG with issue_valid held; NEG only presented once SUB's WB lets decode advance
    wb_before = wb_count;
    exp_q.push_back('{fp: 1'b1, dest: 5'd1, data: 32'h40000000});
    exp_q.push_back('{fp: 1'b1, dest: 5'd2, data: 32'hC0000000});
    issue_valid = 1'b1; issue_opcode = OP_SUB; issue_fp_we = 1'b1; issue_dest = 5'd1;
    step();
    fpu_result = 32'h11111111;
    step();
    fpu_result = 32'h40000000;
    step();
    fpu_result = 32'h22222222;
    @(negedge clk);
    chk("b2b_wb_stall", {31'd0, stall}, 32'd0);
    chk("b2b_wb_ready", {31'd0, issue_ready}, 32'd0);
    step();
    issue_opcode = OP_NEG; issue_dest = 5'd2;
    @(negedge clk);
    chk("b2b_neg_ready", {31'd0, issue_ready}, 32'd1);
    step();
    issue_valid = 1'b0;
    fpu_result = 32'hC0000000;
    @(negedge clk);
    chk("b2b_neg_start", {31'd0, fpu_start}, 32'd1);
    chk("b2b_neg_opcode", {28'd0, fpu_opcode}, {28'd0, OP_NEG});
    step();
    fpu_result = 32'h0;
    for (int i = 0; i < 4; i++) step();
    chk("b2b_wb_count", wb_count - wb_before, 32'd2);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
